// File: rtl/instruction_fetch_queue.sv
// Fetch sequencer: owns the fetch PC, drives instruction memory, buffers {PC, instr} pairs.
// Latency: a fetch written at edge N is at the queue head after edge N (combinational head read).
// Backpressure: Stall holds the head, Halt stops fetching; a full queue only fetches when it also pops.
//
// Ports:
//   Clk, Reset (async, active-high)      clock / reset
//   Redirect, RedirectPC                 flush queue and restart fetch at RedirectPC (word aligned)
//   Halt, Stall                          freeze fetching / hold the head entry
//   IMemAddress, IMemInstruction         byte address out, combinational read data in
//   InstrValid, InstrOut, InstrPC        queue head
//   QueueCount                           current occupancy
//   StallCycles                          saturating count of stalled-valid cycles
//                                        (present only when IFQ_PERF_CNT_EN is defined)
module instruction_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     Redirect,
   input  logic [31:0]              RedirectPC,
   input  logic                     Halt,
   input  logic                     Stall,
   output logic [31:0]              IMemAddress,
   input  logic [31:0]              IMemInstruction,
   output logic                     InstrValid,
   output logic [31:0]              InstrOut,
   output logic [31:0]              InstrPC,
   output logic [$clog2(DEPTH):0]   QueueCount
`ifdef IFQ_PERF_CNT_EN
   ,
   output logic [31:0]              StallCycles
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [0:0] S_FETCH  = 1'b0;
   localparam logic [0:0] S_HALTED = 1'b1;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [0:0]    state_q, state_d;
   logic [31:0]   last_pc_q, last_ins_q;

   logic [31:0]   pc_mem_q  [DEPTH];
   logic [31:0]   ins_mem_q [DEPTH];

   logic          fetch_en;
   logic          pop;
   logic          push;

   // Leaving HALTED takes effect on the same edge Halt drops, so no fetch slot
   // is lost on resume; in both states fetching is enabled exactly when Halt is low.
   always_comb begin
      state_d  = state_q;
      fetch_en = 1'b0;
      case (state_q)
         S_FETCH: begin
            fetch_en = ~Halt;
            if (Halt && !Redirect) state_d = S_HALTED;
         end
         S_HALTED: begin
            fetch_en = ~Halt;
            if (!Halt || Redirect) state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign InstrValid = (count_q != '0);
   assign pop        = InstrValid & ~Stall & ~Redirect;
   // A full queue can still accept a fetch when the head leaves on the same edge.
   assign push       = ~Redirect & fetch_en & ((count_q < CW'(DEPTH)) | pop);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (Redirect) begin
         fetch_pc_d = {RedirectPC[31:2], 2'b00};
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            wr_ptr_d   = wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         fetch_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= S_FETCH;
         last_pc_q  <= '0;
         last_ins_q <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         last_pc_q  <= InstrPC;
         last_ins_q <= InstrOut;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge Clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]  <= fetch_pc_q;
         ins_mem_q[wr_ptr_q] <= IMemInstruction;
      end
   end

   // When empty the head outputs hold the last real head (zero after reset)
   // instead of exposing a stale storage slot.
   assign InstrPC     = InstrValid ? pc_mem_q[rd_ptr_q]  : last_pc_q;
   assign InstrOut    = InstrValid ? ins_mem_q[rd_ptr_q] : last_ins_q;
   assign IMemAddress = fetch_pc_q;
   assign QueueCount  = count_q;

`ifdef IFQ_PERF_CNT_EN
   logic [31:0] stall_cnt_q;

   // Counts cycles decode refused a valid head; Redirect does not clear it.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         stall_cnt_q <= '0;
      end else if (InstrValid && Stall && !Redirect && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign StallCycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        Clk;
   logic        Reset;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic        Halt;
   logic        Stall;
   logic [31:0] IMemAddress;
   logic [31:0] IMemInstruction;
   logic        InstrValid;
   logic [31:0] InstrOut;
   logic [31:0] InstrPC;
   logic [2:0]  QueueCount;
`ifdef IFQ_PERF_CNT_EN
   logic [31:0] StallCycles;
`endif

   instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .Redirect        (Redirect),
      .RedirectPC      (RedirectPC),
      .Halt            (Halt),
      .Stall           (Stall),
      .IMemAddress     (IMemAddress),
      .IMemInstruction (IMemInstruction),
      .InstrValid      (InstrValid),
      .InstrOut        (InstrOut),
      .InstrPC         (InstrPC),
      .QueueCount      (QueueCount)
`ifdef IFQ_PERF_CNT_EN
      ,
      .StallCycles     (StallCycles)
`endif
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Instruction memory: word i holds i*3.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a >> 2) * 32'd3;
   endfunction

   assign IMemInstruction = mem_word(IMemAddress);

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] exp_q[$];
   logic [31:0] mpc;
   logic [31:0] mperf;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   task automatic check_state();
      check("valid", 32'(InstrValid), 32'(exp_q.size() != 0));
      check("count", 32'(QueueCount), 32'(exp_q.size()));
      check("imem_addr", IMemAddress, mpc);
      if (exp_q.size() != 0) check("head_pc", InstrPC, exp_q[0][63:32]);
`ifdef IFQ_PERF_CNT_EN
      check("stall_cycles", StallCycles, mperf);
`endif
   endtask

   // Called at a falling edge: drive inputs, update the model, let one rising edge pass.
   task automatic cyc(input logic rd, input logic [31:0] rpc, input logic hl, input logic st);
      logic        room;
      logic        pop;
      logic        push;
      logic [63:0] e;
      Redirect   = rd;
      RedirectPC = rpc;
      Halt       = hl;
      Stall      = st;
      room = exp_q.size() < DEPTH;
      pop  = (exp_q.size() != 0) && !st && !rd;
      if ((exp_q.size() != 0) && st && !rd && (mperf != 32'hFFFF_FFFF)) mperf++;
      if (pop) begin
         e = exp_q.pop_front();
         check("pop_pc", InstrPC, e[63:32]);
         check("pop_ins", InstrOut, e[31:0]);
      end
      push = !rd && !hl && (room || pop);
      if (rd) begin
         exp_q.delete();
         mpc = {rpc[31:2], 2'b00};
      end else if (push) begin
         exp_q.push_back({mpc, mem_word(mpc)});
         mpc = mpc + 32'd4;
      end
      @(posedge Clk);
      @(negedge Clk);
      check_state();
   endtask

   // Raise reset between edges and check that state clears before any edge.
   task automatic do_reset();
      #2 Reset = 1'b1;
      #1;
      check("rst_valid", 32'(InstrValid), 32'd0);
      check("rst_count", 32'(QueueCount), 32'd0);
      check("rst_imem", IMemAddress, RESET_PC);
      check("rst_pc", InstrPC, 32'd0);
      check("rst_ins", InstrOut, 32'd0);
`ifdef IFQ_PERF_CNT_EN
      check("rst_stall_cycles", StallCycles, 32'd0);
`endif
      @(negedge Clk);
      Reset = 1'b0;
      exp_q.delete();
      mpc   = RESET_PC;
      mperf = 32'd0;
   endtask

   initial begin
      Reset      = 1'b1;
      Redirect   = 1'b0;
      RedirectPC = 32'd0;
      Halt       = 1'b0;
      Stall      = 1'b0;
      mpc        = RESET_PC;
      mperf      = 32'd0;
      @(negedge Clk);
      do_reset();

      // Free-run: PCs 0,4,8,12 with data 0,3,6,9, occupancy stays 1.
      for (int i = 0; i < 5; i++) cyc(1'b0, 32'd0, 1'b0, 1'b0);
      check("freerun_count", 32'(QueueCount), 32'd1);

      // Stall 6 cycles after the first valid head.
      do_reset();
      cyc(1'b0, 32'd0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) cyc(1'b0, 32'd0, 1'b0, 1'b1);
      check("stall_count", 32'(QueueCount), 32'd4);
      check("stall_head", InstrPC, 32'd0);
      check("stall_imem", IMemAddress, 32'h10);
`ifdef IFQ_PERF_CNT_EN
      check("stall_cycles_6", StallCycles, 32'd6);
`endif
      // Full with a pop: push accepted the same edge.
      cyc(1'b0, 32'd0, 1'b0, 1'b0);
      check("full_pop_count", 32'(QueueCount), 32'd4);
      check("full_pop_imem", IMemAddress, 32'h14);
      for (int i = 0; i < 4; i++) cyc(1'b0, 32'd0, 1'b0, 1'b0);

      // Redirect with three entries held.
      do_reset();
      cyc(1'b0, 32'd0, 1'b0, 1'b0);
      cyc(1'b0, 32'd0, 1'b0, 1'b1);
      cyc(1'b0, 32'd0, 1'b0, 1'b1);
      check("pre_redir_count", 32'(QueueCount), 32'd3);
      cyc(1'b1, 32'h0000_0043, 1'b0, 1'b0);
      check("redir_valid", 32'(InstrValid), 32'd0);
      check("redir_imem", IMemAddress, 32'h40);
      cyc(1'b0, 32'd0, 1'b0, 1'b0);
      check("redir_pc", InstrPC, 32'h40);
      check("redir_ins", InstrOut, 32'd48);
      // Continuous redirect keeps the queue empty.
      cyc(1'b1, 32'h0000_0100, 1'b0, 1'b0);
      cyc(1'b1, 32'h0000_0200, 1'b0, 1'b1);
      check("cont_redir_count", 32'(QueueCount), 32'd0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b0, 1'b0);

      // Halt with a full queue: drains, PC frozen, resumes without gaps.
      for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
      check("halt_drained", 32'(QueueCount), 32'd0);
      check("halt_valid", 32'(InstrValid), 32'd0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 32'd0, 1'b0, 1'b0);
      // Halt with Stall held and a redirect while halted.
      cyc(1'b0, 32'd0, 1'b1, 1'b1);
      cyc(1'b1, 32'h0000_0080, 1'b1, 1'b0);
      cyc(1'b0, 32'd0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b0, 1'b0);

      // FetchPC wraps through zero.
      cyc(1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 32'd0, 1'b0, $urandom_range(0, 1) == 1);
      for (int i = 0; i < 30; i++)
         cyc(1'b0, 32'd0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);

      // Asynchronous reset with a full queue.
      for (int i = 0; i < 5; i++) cyc(1'b0, 32'd0, 1'b0, 1'b1);
      check("pre_reset_full", 32'(QueueCount), 32'd4);
      do_reset();
      cyc(1'b0, 32'd0, 1'b0, 1'b0);
      check("post_reset_pc", InstrPC, RESET_PC);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
- Sequences instruction fetch for the single-cycle/pipelined MIPS core.
- Owns the fetch PC and drives the word address into the combinational-read instruction memory (128+ words, byte address, bits [1:0] ignored).
- Buffers fetched {PC, instruction} pairs in a small FIFO so decode stalls do not lose fetches.
- Handles branch/jump redirects by flushing and restarting fetch.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Redirect  input  1  taken branch/jump: flush queue and restart at RedirectPC.
- RedirectPC  input  32  new fetch address; bits [1:0] forced to 0 internally.
- Halt  input  1  freeze fetching (no push); the queue keeps draining.
- Stall  input  1  decode not ready; head entry is held.
- IMemAddress  output  32  byte address to instruction memory; always equals FetchPC.
- IMemInstruction  input  32  combinational read data from instruction memory.
- InstrValid  output  1  queue head is valid.
- InstrOut  output  32  instruction at queue head.
- InstrPC  output  32  byte PC of queue head.
- QueueCount  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset values: FetchPC=RESET_PC, count=0, read/write pointers=0, InstrValid=0, InstrOut=0, InstrPC=0, QueueCount=0. Storage contents are don't-care.
- Signal definitions:
  - Pop = InstrValid & ~Stall & ~Redirect.
  - Push = ~Redirect & ~Halt & ((count<DEPTH) | Pop).
- On Push at the clock edge:
  - Entry {FetchPC, IMemInstruction} is written at the write pointer.
  - FetchPC <= FetchPC+4, wrapping modulo 2^32 with no flag.
  - The write pointer advances.
- On Pop: the read pointer advances.
- Count update: count +1 on Push only, -1 on Pop only, unchanged on both or neither. Pointers wrap modulo DEPTH.
- Full and simultaneous pop: a push is accepted in the same cycle and count stays at DEPTH.
- Empty: InstrValid=0. Stall is ignored. InstrOut/InstrPC hold the last head value and must not be sampled.
- Head outputs are a combinational read of the registered storage: InstrValid=(count!=0).
- Latency: a fetch made at edge N is visible at the head after edge N if the queue was empty; InstrValid rises one cycle after Reset deasserts.
- Redirect has top priority over Push, Pop and Halt. At the edge:
  - count<=0 and pointers<=0.
  - FetchPC<={RedirectPC[31:2],2'b00}.
  - Nothing is pushed or popped.
  - The first redirected instruction is valid one cycle after Redirect drops; a continuous Redirect keeps the queue empty.
- Halt: FetchPC frozen, no push, draining continues. Deasserting Halt resumes at the frozen FetchPC.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); in-flight entries are discarded.
- Control FSM, registered, reset to FETCH:
  - FETCH: normal operation. Go to HALTED when Halt=1 and Redirect=0.
  - HALTED: no push. Go to FETCH when Halt=0, or on any Redirect (the redirect is applied the same edge).
  - State is observable only through push behaviour.

Optional Feature:
- Macro: IFQ_PERF_CNT_EN.
- Defined: adds output port StallCycles [31:0], reset to 0.
  - Increments each cycle InstrValid & Stall & ~Redirect.
  - Saturates at 32'hFFFF_FFFF.
  - Not cleared by Redirect.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then free-run, memory model mem[i]=i*3, Stall=0 -> from the first valid cycle, InstrPC=0,4,8,12 with InstrOut=0,3,6,9 on consecutive cycles; QueueCount stays at 1.
- Stall=1 for 6 cycles after the first valid -> QueueCount reaches 4 and holds. The head stays at PC 0. FetchPC freezes at 0x10 (IMemAddress=0x10). On release, PCs 0,4,8,12,16 appear in order with no gap.
- Queue full (4) with Stall=0 for one cycle -> one pop and one push in the same edge; QueueCount remains 4; IMemAddress advances by 4.
- Queue holding 3 entries, Redirect=1 with RedirectPC=0x0000_0043 -> next cycle InstrValid=0 and QueueCount=0. IMemAddress=0x40. One cycle later InstrPC=0x40 and InstrOut=48.
- Halt=1 for 5 cycles with Stall=0 -> queue drains to 0 and InstrValid drops. IMemAddress is constant. Halt=0 resumes at the frozen PC with no skipped or duplicated PCs.
- Reset pulsed asynchronously between edges with a full queue -> InstrValid=0, QueueCount=0 and IMemAddress=RESET_PC immediately, before the next edge. With IFQ_PERF_CNT_EN defined: StallCycles=0 after reset, and =6 after the 6-cycle stall scenario.
